// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// The CHECK state is only reachable when LOADER_CHECKSUM_EN is defined.
package inst_mem_loader_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/inst_mem_loader_byte_word_packer.sv
// Packs accepted host bytes little-endian into a 32-bit word.
// word_ready pulses combinationally on the 4th byte taken; word is valid from the next cycle.
module inst_mem_loader_byte_word_packer
  import inst_mem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               take,
  input  logic [7:0]         data,
  output logic [INSTR_W-1:0] word,
  output logic               word_ready
);

  logic [1:0] byte_idx;

  // Shifting right places byte 0 in bits [7:0] once four bytes have arrived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (take) begin
      byte_idx <= byte_idx + 2'd1;
      word     <= {data, word[INSTR_W-1:8]};
    end
  end

  assign word_ready = take && (byte_idx == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: streams host bytes into instruction memory, holds the CPU until resident.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = TEXT_BASE
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                StartLoad,
  input  logic [ADDR_WIDTH:0] WordCount,
  input  logic                ByteValid,
  input  logic [7:0]          ByteData,
  output logic                ByteReady,
  output logic                MemWrEn,
  output logic [31:0]         MemWrAddr,
  output logic [INSTR_W-1:0]  MemWrData,
  output logic                CpuHold,
  output logic                LoadDone,
  output logic                LoadError,
  output state_t              dbg_state
);

  // Byte handshake: a byte is consumed on a rising edge where ByteValid && ByteReady.
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state, next_state;
  logic [ADDR_WIDTH:0] word_cnt, word_idx, idx_inc;
  logic [31:0]         addr;
  logic                start_ok, take, word_ready;
  logic                ready_d, wr_d, hold_d, done_d, err_d;

  assign start_ok = StartLoad &&
                    (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign take     = ByteValid && ByteReady && (state == ST_RECV);
  assign idx_inc  = word_idx + ONE;

  inst_mem_loader_byte_word_packer byte_word_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .take       (take),
    .data       (ByteData),
    .word       (MemWrData),
    .word_ready (word_ready)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       check_take;
  assign check_take = ByteValid && ByteReady && (state == ST_CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        csum <= '0;
    else if (start_ok) csum <= '0;
    else if (take)     csum <= csum ^ ByteData;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (StartLoad) begin
          if (WordCount == '0)        next_state = ST_DONE;
          else if (WordCount > DEPTH) next_state = ST_ERROR;
          else                        next_state = ST_RECV;
        end
      end
      ST_RECV:  if (word_ready) next_state = ST_WRITE;
      ST_WRITE: begin
        if (idx_inc == word_cnt) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = ST_CHECK;
`else
          next_state = ST_DONE;
`endif
        end else begin
          next_state = ST_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: if (check_take) next_state = (ByteData == csum) ? ST_DONE : ST_ERROR;
`endif
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered copies line up with state.
  always_comb begin
    ready_d = (next_state == ST_RECV) || (next_state == ST_CHECK);
    wr_d    = (next_state == ST_WRITE);
    hold_d  = (next_state != ST_DONE);
    done_d  = (next_state == ST_DONE);
    err_d   = (next_state == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ByteReady <= 1'b0;
      MemWrEn   <= 1'b0;
      CpuHold   <= 1'b1;
      LoadDone  <= 1'b0;
      LoadError <= 1'b0;
    end else begin
      ByteReady <= ready_d;
      MemWrEn   <= wr_d;
      CpuHold   <= hold_d;
      LoadDone  <= done_d;
      LoadError <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      word_idx <= '0;
      addr     <= BASE_ADDR;
    end else if (start_ok) begin
      word_cnt <= WordCount;
      word_idx <= '0;
      addr     <= BASE_ADDR;
    end else if (state == ST_WRITE) begin
      word_idx <= idx_inc;
      addr     <= addr + 32'd4;
    end
  end

  assign MemWrAddr = addr;
  assign dbg_state = state;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: start-decision table, directed loads, random loads.
// Checksum sequences are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_inst_mem_loader;
  import inst_mem_loader_pkg::*;

  localparam int          AW    = 8;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          StartLoad = 1'b0;
  logic [AW:0]   WordCount = '0;
  logic          ByteValid = 1'b0;
  logic [7:0]    ByteData = '0;
  logic          ByteReady, MemWrEn, CpuHold, LoadDone, LoadError;
  logic [31:0]   MemWrAddr, MemWrData;
  state_t        dbg_state;

  int            checks = 0;
  int            failures = 0;
  int            wr_seen = 0;
  int            cyc = 0;
  int            last_wr_cyc = 0;
  logic [63:0]   exp_q[$];
  logic [7:0]    tx_q[$];
  logic [31:0]   load_w[$];
  logic [63:0]   mon_exp;

  typedef struct {
    int wc;
    bit done;
    bit err;
    bit hold;
    bit ready;
  } vec_t;
  vec_t vecs[6];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StartLoad (StartLoad),
    .WordCount (WordCount),
    .ByteValid (ByteValid),
    .ByteData  (ByteData),
    .ByteReady (ByteReady),
    .MemWrEn   (MemWrEn),
    .MemWrAddr (MemWrAddr),
    .MemWrData (MemWrData),
    .CpuHold   (CpuHold),
    .LoadDone  (LoadDone),
    .LoadError (LoadError),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard on the write port ----------------
  always @(negedge clk) begin
    if (MemWrEn) begin
      wr_seen++;
      last_wr_cyc = cyc;
      check("wr_byte_ready_low", 64'(ByteReady), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write expected",
                 MemWrAddr, MemWrData);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_addr_data", {MemWrAddr, MemWrData}, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    StartLoad = 1'b0;
    ByteValid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start(input int wc);
    WordCount = wc[AW:0];
    StartLoad = 1'b1;
    @(negedge clk);
    StartLoad = 1'b0;
  endtask

  // Presents tx_q bytes; a byte is consumed when valid is high while ready is high.
  task automatic send_bytes(input bit rnd);
    int  budget;
    bit  hs;
    budget = 0;
    while (tx_q.size() != 0 && budget < 20000) begin
      ByteValid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ByteData  = ByteValid ? tx_q[0] : 8'($urandom);
      hs = ByteValid && ByteReady;
      @(negedge clk);
      budget++;
      if (hs) void'(tx_q.pop_front());
    end
    ByteValid = 1'b0;
    check("bytes_all_taken", 64'(tx_q.size()), 64'd0);
  endtask

  // Reference model: words map to consecutive addresses, little-endian byte order,
  // optional XOR trailer; outcome decided from the count and trailer alone.
  task automatic run_load(input int wc, input bit rnd, input logic [7:0] flip);
    logic [7:0]  x;
    logic [31:0] w;
    bit          err;
    int          n, wr_before, gap;
    x = 8'h00;
    tx_q.delete();
    err = (wc > DEPTH);
    gap = 1;
    if (!err) begin
      for (int i = 0; i < wc; i++) begin
        w = load_w[i];
        for (int k = 0; k < 4; k++) begin
          tx_q.push_back(w[8*k +: 8]);
          x = x ^ w[8*k +: 8];
        end
        exp_q.push_back({BASE + 32'(4 * i), w});
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (!err && wc != 0) begin
      tx_q.push_back(x ^ flip);
      if (flip != 8'h00) err = 1'b1;
      gap = 2;
    end
`else
    if (flip != 8'h00) x = x ^ flip;
`endif
    wr_before = wr_seen;
    pulse_start(wc);
    send_bytes(rnd);
    n = 0;
    while (!(LoadDone || LoadError) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("load_finished", 64'(n < 2000), 64'd1);
    check("load_done", 64'(LoadDone), 64'(!err));
    check("load_error", 64'(LoadError), 64'(err));
    check("cpu_hold", 64'(CpuHold), 64'(err));
    check("ready_after", 64'(ByteReady), 64'd0);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    check("write_count", 64'(wr_seen - wr_before), 64'((wc > DEPTH) ? 0 : wc));
    if (!rnd && wc != 0 && wc <= DEPTH)
      check("done_after_last_write", 64'(cyc - last_wr_cyc), 64'(gap));
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{wc: 0,         done: 1'b1, err: 1'b0, hold: 1'b0, ready: 1'b0};
    vecs[1] = '{wc: DEPTH + 1, done: 1'b0, err: 1'b1, hold: 1'b1, ready: 1'b0};
    vecs[2] = '{wc: 2*DEPTH-1, done: 1'b0, err: 1'b1, hold: 1'b1, ready: 1'b0};
    vecs[3] = '{wc: 1,         done: 1'b0, err: 1'b0, hold: 1'b1, ready: 1'b1};
    vecs[4] = '{wc: DEPTH,     done: 1'b0, err: 1'b0, hold: 1'b1, ready: 1'b1};
    vecs[5] = '{wc: 200,       done: 1'b0, err: 1'b0, hold: 1'b1, ready: 1'b1};

    // Reset and quiet idle
    do_reset();
    check("reset_addr", 64'(MemWrAddr), 64'(BASE));
    check("reset_data", 64'(MemWrData), 64'd0);
    for (int i = 0; i < 20; i++) begin
      check("idle_outputs", 64'({CpuHold, LoadDone, LoadError, ByteReady, MemWrEn}), 64'b10000);
      @(negedge clk);
    end

    // Start decision table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      pulse_start(vecs[i].wc);
      check("vec_done", 64'(LoadDone), 64'(vecs[i].done));
      check("vec_err", 64'(LoadError), 64'(vecs[i].err));
      check("vec_hold", 64'(CpuHold), 64'(vecs[i].hold));
      check("vec_ready", 64'(ByteReady), 64'(vecs[i].ready));
      check("vec_addr", 64'(MemWrAddr), 64'(BASE));
    end

    // Directed two-word load, then the same with gappy valid
    do_reset();
    load_w.delete();
    load_w.push_back(32'h1234_5678);
    load_w.push_back(32'hDEAD_BEEF);
    run_load(2, 1'b0, 8'h00);
    run_load(2, 1'b1, 8'h00);

    // Zero count, oversize count, then recovery from ERROR
    run_load(0, 1'b0, 8'h00);
    run_load(DEPTH + 1, 1'b0, 8'h00);
    load_w.delete();
    load_w.push_back(32'hCAFE_F00D);
    run_load(1, 1'b0, 8'h00);

    // Reset after two bytes of the first word
    tx_q.delete();
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    pulse_start(1);
    send_bytes(1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 64'({CpuHold, LoadDone, LoadError, ByteReady, MemWrEn}), 64'b10000);
    check("midreset_addr", 64'(MemWrAddr), 64'(BASE));
    check("midreset_data", 64'(MemWrData), 64'd0);
    check("midreset_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_w.delete();
    load_w.push_back(32'hA5C3_0F96);
    run_load(1, 1'b0, 8'h00);

`ifdef LOADER_CHECKSUM_EN
    load_w.delete();
    load_w.push_back(32'h0804_0201);
    run_load(1, 1'b0, 8'h00);
    run_load(1, 1'b0, 8'h01);
`endif

    // Full-depth load reaches the last word address
    load_w.delete();
    for (int i = 0; i < DEPTH; i++) load_w.push_back($urandom);
    run_load(DEPTH, 1'b0, 8'h00);

    // Random loads
    for (int r = 0; r < 8; r++) begin
      int          wc;
      logic [7:0]  flip;
      wc = $urandom_range(1, 6);
      flip = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      load_w.delete();
      for (int i = 0; i < wc; i++) load_w.push_back($urandom);
      run_load(wc, 1'b1, flip);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Boot-time sequencer that fills instruction memory from a byte stream (UART/debug bridge) and holds the CPU until the program is resident.
- Assembles little-endian bytes into 32-bit words and issues one write per word to the instruction memory write port.
- Sits between the host byte source, the instruction memory and the CPU reset/stall logic.

Parameters:
- ADDR_WIDTH, 8, log2 of instruction memory depth in words (DEPTH = 2^ADDR_WIDTH).
- BASE_ADDR, 32'h0040_0000, byte address of word 0 (text segment base).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- StartLoad  input  1  one-cycle start pulse; honoured in IDLE, DONE and ERROR only.
- WordCount  input  ADDR_WIDTH+1  number of words to load; sampled on StartLoad.
- ByteValid  input  1  host byte valid.
- ByteData  input  8  host byte.
- ByteReady  output  1  loader can accept a byte.
- MemWrEn  output  1  instruction memory write strobe, one cycle per word.
- MemWrAddr  output  32  byte address of the write: BASE_ADDR + 4*index.
- MemWrData  output  32  assembled instruction word.
- CpuHold  output  1  keeps the CPU in reset/stall while high.
- LoadDone  output  1  program fully written.
- LoadError  output  1  load aborted.

Behaviour:
- Reset values: state IDLE, CpuHold=1, LoadDone=0, LoadError=0, ByteReady=0, MemWrEn=0, MemWrAddr=BASE_ADDR, MemWrData=0, internal counters 0.
- Reset is asynchronous. Asserting it mid-load aborts the load with no further writes; words already written stay in memory.
- All outputs are registered. FSM states: IDLE, RECV, WRITE, DONE, ERROR (plus CHECK with the optional feature).
- IDLE: wait for StartLoad.
  - WordCount==0: go to DONE.
  - WordCount>DEPTH: go to ERROR.
  - Otherwise latch the count, clear word index and byte index, go to RECV.
- RECV: ByteReady=1.
  - A handshake occurs when ByteValid && ByteReady.
  - Byte k of a word (k=0..3) goes to bits [8k+7:8k], so byte 0 is the LSB.
  - The 4th handshake moves the FSM to WRITE.
  - ByteValid without ByteReady is ignored; ByteData is don't-care when ByteValid=0.
- WRITE (exactly one cycle):
  - MemWrEn=1, ByteReady=0; MemWrAddr and MemWrData are stable during this cycle.
  - Word index increments. If the new index equals the count, go to DONE (or CHECK); otherwise go to RECV.
  - Latency: MemWrEn rises the cycle after the 4th byte handshake. Maximum throughput is one word per 5 cycles.
- DONE: LoadDone=1, CpuHold=0, ByteReady=0.
- ERROR: LoadError=1, CpuHold=1, ByteReady=0.
- StartLoad in DONE or ERROR clears LoadDone/LoadError, sets CpuHold=1 and re-evaluates WordCount exactly as in IDLE.
- StartLoad in RECV, WRITE or CHECK is ignored.
- Index arithmetic: the word index is ADDR_WIDTH+1 bits wide. Loading WordCount==DEPTH is legal; the last write goes to BASE_ADDR + 4*(DEPTH-1). The address computation wraps modulo 2^32 (no overflow handling).

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every accepted data byte is kept, cleared on each accepted StartLoad.
  - After the last WRITE the FSM enters CHECK with ByteReady=1 and accepts one extra byte.
  - Byte equal to the running XOR: go to DONE. Byte not equal: go to ERROR.
  - WordCount==0 goes straight to DONE with no checksum byte.
- Undefined: the CHECK state, XOR register and extra byte do not exist; the last WRITE goes directly to DONE.

Decomposition:
- Shared package (cpu_pkg):
  - State encoding constants (IDLE/RECV/WRITE/CHECK/DONE/ERROR).
  - BASE_ADDR default text-segment constant.
  - Instruction word width constant (32).
- One natural sub-module, byte_word_packer: byte handshake, 2-bit byte counter, 32-bit shift register, word-ready pulse.
- The FSM, address and hold logic stay in the top module.

Test Plan:
- Reset then idle → CpuHold=1, LoadDone=0, ByteReady=0, MemWrEn=0; no activity for 20 cycles.
- StartLoad, WordCount=2, bytes 78 56 34 12 EF BE AD DE with ByteValid always high → MemWrEn twice: (0x0040_0000, 0x1234_5678) and (0x0040_0004, 0xDEAD_BEEF); LoadDone=1 and CpuHold=0 in the cycle after the second write.
- Same load with ByteValid toggling randomly (~50%) → identical write sequence; no byte lost or duplicated; ByteReady=0 in every WRITE cycle.
- WordCount=0 → DONE with no writes. WordCount=DEPTH+1 (257 at default) → LoadError=1, CpuHold=1, no writes. Then StartLoad with WordCount=1 → LoadError clears and the load proceeds normally.
- rst_n asserted after 2 of 4 bytes of word 1 → all outputs at reset values immediately; no MemWrEn. A following clean load with WordCount=1 writes the correct word to BASE_ADDR.
- With LOADER_CHECKSUM_EN, WordCount=1, bytes 01 02 04 08:
  - checksum 0x0F → LoadDone=1;
  - checksum 0x0E → LoadError=1, CpuHold stays 1;
  - in both cases the word 0x0804_0201 is written exactly once.
